// File: rtl/register_renamer_pkg.sv
// Shared types for the register renamer: physical/architectural addresses,
// global-control input and the renamer FSM encoding.
package register_renamer_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;

    typedef logic [5:0] phys_addr_t;
    typedef logic [4:0] arch_addr_t;

    typedef struct packed {
        logic fetch_flush;
    } gc_outputs_t;

    typedef enum logic {RN_INIT, RN_RUN} rn_state_t;

    // Free-list preload value for INIT step i: phys 32+i
    function automatic phys_addr_t fl_preload(input logic [4:0] i);
        return {1'b1, i};
    endfunction
endpackage

// File: rtl/register_renamer_free_list.sv
// Dual-push, single-pop 64-entry free list of physical registers.
// Optional macro RENAMER_FREE_LIST_BYPASS_EN forwards push0 to the head when empty.
module register_renamer_free_list
    import register_renamer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push0,
    input  phys_addr_t i_push0_data,
    input  logic       i_push1,
    input  phys_addr_t i_push1_data,
    input  logic       i_pop,
    output phys_addr_t o_head,
    output logic       o_avail
);
    phys_addr_t r_mem [PHYS_REGS];
    logic [5:0] r_rd_ptr, r_wr_ptr;
    logic [6:0] r_count;
    logic [7:0] w_count_nxt;
    logic [5:0] w_wr1;

    // push1 lands behind push0 when both are active
    assign w_wr1       = r_wr_ptr + 6'(i_push0);
    assign w_count_nxt = {1'b0, r_count} + 8'(i_push0) + 8'(i_push1) - 8'(i_pop);

    always_ff @(posedge i_clk) begin
        if (i_push0) r_mem[r_wr_ptr] <= i_push0_data;
        if (i_push1) r_mem[w_wr1]    <= i_push1_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + 6'(i_pop);
            r_wr_ptr <= r_wr_ptr + 6'(i_push0) + 6'(i_push1);
            r_count  <= w_count_nxt[6:0];
        end
    end

`ifdef RENAMER_FREE_LIST_BYPASS_EN
    logic w_byp;
    assign w_byp   = (r_count == '0) & i_push0;
    assign o_head  = w_byp ? i_push0_data : r_mem[r_rd_ptr];
    assign o_avail = (r_count != '0) | w_byp;
`else
    assign o_head  = r_mem[r_rd_ptr];
    assign o_avail = (r_count != '0);
`endif

    // Catches both overflow past 64 and popping an empty list
    a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst_n) w_count_nxt <= 8'd64);
endmodule

// File: rtl/register_renamer.sv
// Decode-stage register renamer: map table, per-ID rename records and free list.
// Optional macro RENAMER_FREE_LIST_BYPASS_EN (see free list) enables zero-latency recycle.
module register_renamer
    import register_renamer_pkg::*;
#(
    parameter int NUM_WB_GROUPS = 2,
    parameter int READ_PORTS    = 2,
    parameter int MAX_IDS       = 8,
    parameter int USE_ZERO      = 0,
    localparam int GW  = (NUM_WB_GROUPS > 1) ? $clog2(NUM_WB_GROUPS) : 1,
    localparam int IDW = (MAX_IDS > 1) ? $clog2(MAX_IDS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  gc_outputs_t                    i_gc,
    input  arch_addr_t [READ_PORTS-1:0]    i_decode_rs_addr,
    input  arch_addr_t                     i_decode_rd_addr,
    input  logic                           i_decode_uses_rd,
    input  logic [GW-1:0]                  i_decode_wb_group,
    input  logic [IDW-1:0]                 i_decode_id,
    input  logic                           i_decode_advance,
    output phys_addr_t [READ_PORTS-1:0]    o_decode_phys_rs_addr,
    output logic [READ_PORTS-1:0][GW-1:0]  o_decode_rs_wb_group,
    output phys_addr_t                     o_decode_phys_rd_addr,
    output logic                           o_rename_ready,
    input  logic                           i_retire_valid,
    input  logic [IDW-1:0]                 i_retire_id,
    input  logic                           i_squash_valid,
    input  logic [IDW-1:0]                 i_squash_id
);
    rn_state_t  r_state, w_state_nxt;
    logic [4:0] r_init_cnt;
    logic       w_run;

    phys_addr_t    r_map_phys [ARCH_REGS];
    logic [GW-1:0] r_map_grp  [ARCH_REGS];

    arch_addr_t    r_rec_rd   [MAX_IDS];
    phys_addr_t    r_rec_old  [MAX_IDS];
    logic [GW-1:0] r_rec_grp  [MAX_IDS];
    phys_addr_t    r_rec_new  [MAX_IDS];
    logic [MAX_IDS-1:0] r_rec_vld;

    logic       w_ready, w_rename, w_ret_push, w_sq_push, w_fl_avail, w_push0;
    phys_addr_t w_fl_head, w_push0_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RN_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RN_INIT) r_init_cnt <= r_init_cnt + 5'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            RN_INIT: if (r_init_cnt == 5'd31) w_state_nxt = RN_RUN;
            RN_RUN:  w_run = 1'b1;
            default: w_state_nxt = RN_INIT;
        endcase
    end

    // A squash owns the map write port, so it blocks renaming in the same cycle
    assign w_ready    = w_run & w_fl_avail & ~i_squash_valid;
    assign w_rename   = i_decode_advance & i_decode_uses_rd & ((USE_ZERO != 0) | (|i_decode_rd_addr))
                      & ~i_gc.fetch_flush & w_ready;
    assign w_ret_push = w_run & i_retire_valid & r_rec_vld[i_retire_id];
    assign w_sq_push  = w_run & i_squash_valid & r_rec_vld[i_squash_id];

    assign w_push0      = ~w_run | w_ret_push;
    assign w_push0_data = w_run ? r_rec_old[i_retire_id] : fl_preload(r_init_cnt);

    register_renamer_free_list u_free_list (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push0      (w_push0),
        .i_push0_data (w_push0_data),
        .i_push1      (w_sq_push),
        .i_push1_data (r_rec_new[i_squash_id]),
        .i_pop        (w_rename),
        .o_head       (w_fl_head),
        .o_avail      (w_fl_avail)
    );

    always_ff @(posedge i_clk) begin
        if (!w_run) begin
            r_map_phys[r_init_cnt] <= {1'b0, r_init_cnt};
            r_map_grp[r_init_cnt]  <= '0;
        end else if (w_sq_push) begin
            r_map_phys[r_rec_rd[i_squash_id]] <= r_rec_old[i_squash_id];
            r_map_grp[r_rec_rd[i_squash_id]]  <= r_rec_grp[i_squash_id];
        end else if (w_rename) begin
            r_map_phys[i_decode_rd_addr] <= w_fl_head;
            r_map_grp[i_decode_rd_addr]  <= i_decode_wb_group;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rename) begin
            r_rec_rd[i_decode_id]  <= i_decode_rd_addr;
            r_rec_old[i_decode_id] <= r_map_phys[i_decode_rd_addr];
            r_rec_grp[i_decode_id] <= r_map_grp[i_decode_rd_addr];
            r_rec_new[i_decode_id] <= w_fl_head;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                     r_rec_vld <= '0;
        else if (w_run & i_decode_advance) r_rec_vld[i_decode_id] <= w_rename;
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rs
        assign o_decode_phys_rs_addr[p] = r_map_phys[i_decode_rs_addr[p]];
        assign o_decode_rs_wb_group[p]  = r_map_grp[i_decode_rs_addr[p]];
    end

    assign o_decode_phys_rd_addr = w_fl_head;
    assign o_rename_ready        = w_ready;
endmodule

// File: tb/tb_register_renamer.sv
module tb_register_renamer;
    import register_renamer_pkg::*;

`ifdef RENAMER_FREE_LIST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    gc_outputs_t gc;
    arch_addr_t [1:0] rs;
    arch_addr_t rd;
    logic uses, grp, adv, rv, sv;
    logic [2:0] did, rid, sid;
    phys_addr_t [1:0] prs;
    logic [1:0][0:0] prs_grp;
    phys_addr_t prd;
    logic ready;

    always #5 clk = ~clk;

    register_renamer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_gc(gc),
        .i_decode_rs_addr(rs), .i_decode_rd_addr(rd), .i_decode_uses_rd(uses),
        .i_decode_wb_group(grp), .i_decode_id(did), .i_decode_advance(adv),
        .o_decode_phys_rs_addr(prs), .o_decode_rs_wb_group(prs_grp),
        .o_decode_phys_rd_addr(prd), .o_rename_ready(ready),
        .i_retire_valid(rv), .i_retire_id(rid), .i_squash_valid(sv), .i_squash_id(sid)
    );

    typedef struct { int kind; int exp; } sb_t;
    sb_t sb[$];
    int checks = 0, errors = 0;

    int m_map[32], m_grp[32], m_rd[8], m_old[8], m_ogrp[8], m_new[8];
    bit m_vld[8];
    int fq[$];
    int edges;
    int inflight[$];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin m_map[i] = i; m_grp[i] = 0; end
        for (int i = 0; i < 8; i++) m_vld[i] = 0;
        fq.delete();
        for (int i = 32; i < 64; i++) fq.push_back(i);
        edges = 0;
        inflight.delete();
    endfunction

    function automatic void expect_val(int kind, int exp);
        sb_t e;
        e.kind = kind; e.exp = exp;
        sb.push_back(e);
    endfunction

    task automatic check_reset(input string where);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset state (%s) at %0t: rename_ready=%b expected 0", where, $time, ready);
        end
    endtask

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL timeout at %0t: simulation did not finish", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : monitor
        sb_t e;
        logic [31:0] act;
        string nm;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    0: begin act = 32'(ready);      nm = "rename_ready"; end
                    1: begin act = 32'(prs[0]);     nm = "rs0_phys"; end
                    2: begin act = 32'(prs_grp[0]); nm = "rs0_group"; end
                    3: begin act = 32'(prs[1]);     nm = "rs1_phys"; end
                    4: begin act = 32'(prs_grp[1]); nm = "rs1_group"; end
                    default: begin act = 32'(prd);  nm = "rd_head"; end
                endcase
                checks++;
                if (act !== 32'(e.exp)) begin
                    errors++;
                    $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, e.exp);
                end
            end
        end
    end

    task automatic step(input bit a, input int d_rd, input bit u, input int g, input int id,
                        input int r0, input int r1, input bit rtv, input int rti,
                        input bit sqv, input int sqi, input bit fl);
        bit run, byp, er, ren;
        int h;
        adv = a; rd = 5'(d_rd); uses = u; grp = 1'(g); did = 3'(id);
        rs[0] = 5'(r0); rs[1] = 5'(r1);
        rv = rtv; rid = 3'(rti); sv = sqv; sid = 3'(sqi); gc.fetch_flush = fl;
        run = (edges >= 32);
        byp = BYP && fq.size() == 0 && rtv && m_vld[rti];
        er  = run && (fq.size() > 0 || byp) && !sqv;
        expect_val(0, int'(er));
        if (run) begin
            expect_val(1, m_map[r0]); expect_val(2, m_grp[r0]);
            expect_val(3, m_map[r1]); expect_val(4, m_grp[r1]);
        end
        if (er) expect_val(5, fq.size() > 0 ? fq[0] : m_old[rti]);
        @(posedge clk);
        if (!run) edges++;
        else begin
            ren = a && u && d_rd != 0 && !fl && er;
            if (rtv && m_vld[rti]) fq.push_back(m_old[rti]);
            if (sqv && m_vld[sqi]) begin
                fq.push_back(m_new[sqi]);
                m_map[m_rd[sqi]] = m_old[sqi];
                m_grp[m_rd[sqi]] = m_ogrp[sqi];
            end
            if (ren) begin
                h = fq.pop_front();
                m_rd[id] = d_rd; m_old[id] = m_map[d_rd]; m_ogrp[id] = m_grp[d_rd];
                m_new[id] = h; m_vld[id] = 1;
                m_map[d_rd] = h; m_grp[d_rd] = g;
            end else if (a) m_vld[id] = 0;
        end
        #1;
    endtask

    task automatic idle(input int r0, input int r1);
        step(0, 0, 0, 0, 0, r0, r1, 0, 0, 0, 0, 0);
    endtask

    function automatic bit in_flight(int id);
        foreach (inflight[i]) if (inflight[i] == id) return 1;
        return 0;
    endfunction

    initial begin : stim
        int k, id, r0, nrd;
        bit a, u, f, rtv, sqv;
        gc = '0; rs = '0; rd = '0; uses = 0; grp = 0; did = '0; adv = 0;
        rv = 0; rid = '0; sv = 0; sid = '0;
        model_reset();
        expect_val(0, 0);
        #1 check_reset("power-on");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (32) idle(5, 0);
        idle(5, 0);
        step(1, 5, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 5, 7, 1, 0, 0, 0, 0);
        step(1, 7, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        step(1, 7, 1, 0, 2, 7, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 7, 5, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 0, 7, 5, 0, 0, 1, 1, 0);
        idle(7, 5);
        step(1, 0, 1, 1, 3, 0, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 7, 1, 3, 0, 0, 0);
        idle(0, 5);

        for (int c = 0; c < 600; c++) begin
            sqv = inflight.size() > 0 && $urandom_range(0, 99) < 12;
            rtv = inflight.size() > (sqv ? 1 : 0) && $urandom_range(0, 3) == 0;
            f   = $urandom_range(0, 19) == 0;
            a   = !sqv && inflight.size() < 8 && fq.size() > 0 && $urandom_range(0, 99) < 70;
            id  = 0;
            if (a) begin
                do id = $urandom_range(0, 7); while (in_flight(id));
            end
            u   = $urandom_range(0, 4) != 0;
            nrd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31);
            r0  = $urandom_range(0, 31);
            step(a, nrd, u, $urandom_range(0, 1), id, r0, $urandom_range(0, 31),
                 rtv, rtv ? inflight[0] : 0, sqv, sqv ? inflight[inflight.size()-1] : 0, f);
            if (sqv) void'(inflight.pop_back());
            if (rtv) void'(inflight.pop_front());
            if (a && !f) inflight.push_back(id);
        end
        while (inflight.size() > 0) begin
            step(0, 0, 0, 0, 0, 1, 2, 1, inflight[0], 0, 0, 0);
            void'(inflight.pop_front());
        end
        idle(3, 4);

        rst_n = 1'b0;
        expect_val(0, 0);
        #1 check_reset("mid-operation");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        fork
            begin : init_wait
                int cyc = 0;
                while (ready !== 1'b1 && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                end
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL wait expired at %0t: rename_ready not 1 within 40 cycles of reset", $time);
                end
            end
        join_none
        repeat (32) idle(1, 2);
        step(0, 0, 0, 0, 0, 5, 6, 1, 5, 0, 0, 0);

        k = 0;
        while (fq.size() > 0) begin
            step(1, 1 + (k % 31), 1, k % 2, k % 8, 1, 2, 0, 0, 0, 0, 0);
            k++;
        end
        idle(1, 2);
        step(BYP, 9, 1, 1, k % 8, 9, 1, 1, (k - 1) % 8, 0, 0, 0);
        idle(9, 1);
        idle(9, 1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
